// File: rtl/lsu_pkg.sv
// Shared types for the MMIO load-store unit: access sizes, FSM states, IO windows.
// Pure declarations, no logic.
// Not applicable to flow control.
package lsu_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } size_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DMEM_WAIT = 2'd1,
    RESP      = 2'd2
  } state_e;

  localparam logic [3:0] WIN_OUT = 4'h0;
  localparam logic [3:0] WIN_IN  = 4'h8;

  typedef struct packed {
    logic       we;
    logic [2:0] size;
    logic [1:0] off;
  } req_t;

  // Encodings with no meaning, plus unsigned variants used as store sizes.
  function automatic logic size_bad(input logic [2:0] size, input logic we);
    return (size == 3'b011) || (size[2] && (we || size[1]));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: size + addr[1:0] -> store mask/data, extended load data, misalign flag.
// Combinational, zero latency.
// No flow control; used only while a request is being accepted or answered.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  bmask,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [31:0] lane;

  always_comb begin
    bmask    = 4'b0000;
    st_lanes = st_data;
    misalign = 1'b0;
    lane     = ld_word >> {off, 3'b000};
    ld_data  = lane;
    case (size[1:0])
      2'b00: begin
        bmask    = 4'b0001 << off;
        st_lanes = {4{st_data[7:0]}};
      end
      2'b01: begin
        bmask    = 4'b0011 << off;
        st_lanes = {2{st_data[15:0]}};
        misalign = off[0];
      end
      2'b10: begin
        bmask    = 4'b1111;
        misalign = |off;
      end
      default: ;
    endcase
    case (size)
      SZ_B:    ld_data = {{24{lane[7]}}, lane[7:0]};
      SZ_BU:   ld_data = {24'h0, lane[7:0]};
      SZ_H:    ld_data = {{16{lane[15]}}, lane[15:0]};
      SZ_HU:   ld_data = {16'h0, lane[15:0]};
      default: ld_data = lane;
    endcase
  end

endmodule

// File: rtl/lsu_mmio.sv
// Handshaked load-store unit fronting data memory and MMIO output/input register banks.
// Latency: error/IO one cycle after accept; DMEM one cycle after ack (or TIMEOUT cycles).
// req_ready only in IDLE; response is a one-cycle pulse with no back-pressure.
module lsu_mmio
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DMEM_AW     = 13,
  parameter int N_OUT       = 8,
  parameter int N_IN        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [2:0]           req_size,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [DMEM_AW-1:0]   dmem_addr,
  output logic [31:0]          dmem_wdata,
  output logic [3:0]           dmem_bmask,
  output logic                 dmem_wren,
  output logic                 dmem_rden,
  input  logic [31:0]          dmem_rdata,
  input  logic                 dmem_ack,
  output logic [N_OUT*32-1:0]  io_out,
  input  logic [N_IN*32-1:0]   io_in
);

  localparam int              TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);
  localparam logic [6:0]      N_OUT_L = 7'(N_OUT);
  localparam logic [6:0]      N_IN_L  = 7'(N_IN);

  state_e           state;
  req_t             rq;
  logic [TW-1:0]    timer;
  logic [31:0]      out_regs [N_OUT];
  logic [N_IN*32-1:0] sync_q [SYNC_STAGES];

  logic [3:0]  win;
  logic [5:0]  idx;
  logic        is_io, out_hit, in_hit, req_err, accept, io_wr;
  logic [31:0] io_word, al_word, st_lanes, ld_data;
  logic [2:0]  al_size;
  logic [1:0]  al_off;
  logic [3:0]  bmask;
  logic        misalign;
  logic        unused_addr;

  assign win     = req_addr[11:8];
  assign idx     = req_addr[7:2];
  assign is_io   = req_addr[ADDR_W-2];
  assign out_hit = (win == WIN_OUT) && ({1'b0, idx} < N_OUT_L);
  assign in_hit  = (win == WIN_IN) && ({1'b0, idx} < N_IN_L);
  assign req_err = size_bad(req_size, req_we) | misalign | (is_io & ~out_hit & ~in_hit);

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  // Stores into the input window are dropped silently; only the output bank is writable.
  assign io_wr     = accept & req_we & is_io & ~req_err & out_hit;
  assign unused_addr = ^req_addr;

  always_comb begin
    io_word = '0;
    for (int k = 0; k < N_OUT; k++)
      if (out_hit && idx == 6'(k)) io_word = out_regs[k];
    for (int k = 0; k < N_IN; k++)
      if (in_hit && idx == 6'(k)) io_word = sync_q[SYNC_STAGES-1][32*k +: 32];
  end

  // One aligner serves both the incoming request and the pending DMEM load.
  assign al_size = (state == IDLE) ? req_size      : rq.size;
  assign al_off  = (state == IDLE) ? req_addr[1:0] : rq.off;
  assign al_word = (state == IDLE) ? io_word       : dmem_rdata;

  lsu_lane_align u_align (
    .size     (al_size),
    .off      (al_off),
    .st_data  (req_wdata),
    .ld_word  (al_word),
    .bmask    (bmask),
    .st_lanes (st_lanes),
    .ld_data  (ld_data),
    .misalign (misalign)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rq         <= '0;
      timer      <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_bmask <= '0;
      dmem_wren  <= 1'b0;
      dmem_rden  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          rq <= '{we: req_we, size: req_size, off: req_addr[1:0]};
          if (req_err) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end else if (is_io) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            if (!req_we) rsp_rdata <= ld_data;
          end else begin
            state      <= DMEM_WAIT;
            timer      <= '0;
            dmem_addr  <= {req_addr[DMEM_AW-1:2], 2'b00};
            dmem_wdata <= st_lanes;
            dmem_bmask <= req_we ? bmask : 4'b0000;
            dmem_wren  <= req_we;
            dmem_rden  <= ~req_we;
          end
        end
        DMEM_WAIT: begin
          // An ack in the final timer cycle takes priority over the timeout.
          if (dmem_ack) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            dmem_wren <= 1'b0;
            dmem_rden <= 1'b0;
            if (!rq.we) rsp_rdata <= ld_data;
          end else if (TIMEOUT != 0 && timer == T_LAST) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            dmem_wren <= 1'b0;
            dmem_rden <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_OUT; k++) out_regs[k] <= '0;
    end else if (io_wr) begin
      for (int k = 0; k < N_OUT; k++)
        if (idx == 6'(k))
          for (int b = 0; b < 4; b++)
            if (bmask[b]) out_regs[k][8*b +: 8] <= st_lanes[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= io_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign io_out[32*k +: 32] = out_regs[k];
  end

endmodule

// File: tb/tb_lsu_mmio.sv
// Directed bench for lsu_mmio: DMEM/IO loads and stores, errors, timeout, reset, input sync.
module tb_lsu_mmio;

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  logic         clk = 1'b0, rst = 1'b0;
  logic         req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [15:0]  req_addr = '0;
  logic [2:0]   req_size = '0;
  logic [31:0]  req_wdata = '0;
  logic         rsp_valid, rsp_err;
  logic [31:0]  rsp_rdata;
  logic [12:0]  dmem_addr;
  logic [31:0]  dmem_wdata, dmem_rdata = '0;
  logic [3:0]   dmem_bmask;
  logic         dmem_wren, dmem_rden, dmem_ack = 1'b0;
  logic [255:0] io_out;
  logic [63:0]  io_in = '0;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_mmio dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_bmask(dmem_bmask),
    .dmem_wren(dmem_wren), .dmem_rden(dmem_rden), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .io_out(io_out), .io_in(io_in)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send(input logic we, input logic [15:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Acks after n further edges; checks no response leaks out before the ack.
  task automatic dmem_reply(input string tag, input int n, input logic [31:0] word);
    logic early;
    early = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rsp_valid) early = 1'b1;
    end
    check({tag, ".early"}, 32'(early), 32'd0);
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = word;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic [31:0] rdata, input logic err);
    check({tag, ".vld"}, 32'(rsp_valid), 32'd1);
    check({tag, ".rdata"}, rsp_rdata, rdata);
    check({tag, ".err"}, 32'(rsp_err), 32'(err));
    @(posedge clk);
    #1;
    check({tag, ".drop"}, 32'(rsp_valid), 32'd0);
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [2:0]  size;
    logic [31:0] word;
    logic [31:0] exp;
  } ld_vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] lanes;
  } st_vec_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [2:0]  size;
  } err_vec_t;

  ld_vec_t  lds [7];
  st_vec_t  sts [4];
  err_vec_t errs [9];

  initial begin
    lds = '{
      '{16'h0006, B,  32'h80FF1234, 32'hFFFFFFFF},
      '{16'h0006, BU, 32'h80FF1234, 32'h000000FF},
      '{16'h0002, H,  32'h80FF1234, 32'hFFFF80FF},
      '{16'h0002, HU, 32'h80FF1234, 32'h000080FF},
      '{16'h0000, W,  32'h80FF1234, 32'h80FF1234},
      '{16'h0007, B,  32'h80FF1234, 32'hFFFFFF80},
      '{16'h0104, BU, 32'h80FF1234, 32'h00000034}
    };
    sts = '{
      '{16'h0003, B, 32'h0000005A, 4'b1000, 32'h5A5A5A5A},
      '{16'h0002, H, 32'h00001234, 4'b1100, 32'h12341234},
      '{16'h0001, B, 32'h000000C3, 4'b0010, 32'hC3C3C3C3},
      '{16'h0000, H, 32'h0000ABCD, 4'b0011, 32'hABCDABCD}
    };
    errs = '{
      '{1'b0, 16'h0002, W},
      '{1'b0, 16'h0001, H},
      '{1'b0, 16'h0000, 3'b011},
      '{1'b1, 16'h0000, BU},
      '{1'b0, 16'h4200, W},
      '{1'b0, 16'h4020, W},
      '{1'b0, 16'h4808, W},
      '{1'b1, 16'h4001, W},
      '{1'b1, 16'h0003, H}
    };

    repeat (3) @(posedge clk);
    #1;
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rden", 32'(dmem_rden), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.wren", 32'(dmem_wren), 32'd0);
    check("rst.io_out0", io_out[31:0], 32'h0);

    // Word store to DMEM, ack three cycles after accept.
    send(1'b1, 16'h0004, W, 32'hAABBCCDD);
    check("sw.wren", 32'(dmem_wren), 32'd1);
    check("sw.rden", 32'(dmem_rden), 32'd0);
    check("sw.addr", 32'(dmem_addr), 32'h0004);
    check("sw.bmask", 32'(dmem_bmask), 32'hF);
    check("sw.wdata", dmem_wdata, 32'hAABBCCDD);
    check("sw.busy", 32'(req_ready), 32'd0);
    dmem_reply("sw", 2, 32'h0);
    check("sw.wren_off", 32'(dmem_wren), 32'd0);
    expect_rsp("sw", 32'h0, 1'b0);

    foreach (lds[i]) begin
      send(1'b0, lds[i].addr, lds[i].size, 32'h0);
      check($sformatf("ld%0d.rden", i), 32'(dmem_rden), 32'd1);
      check($sformatf("ld%0d.addr", i), 32'(dmem_addr), 32'(lds[i].addr & 16'h1FFC));
      dmem_reply($sformatf("ld%0d", i), 0, lds[i].word);
      check($sformatf("ld%0d.rden_off", i), 32'(dmem_rden), 32'd0);
      expect_rsp($sformatf("ld%0d", i), lds[i].exp, 1'b0);
    end

    foreach (sts[i]) begin
      send(1'b1, sts[i].addr, sts[i].size, sts[i].wdata);
      check($sformatf("st%0d.bmask", i), 32'(dmem_bmask), 32'(sts[i].mask));
      check($sformatf("st%0d.wdata", i), dmem_wdata, sts[i].lanes);
      dmem_reply($sformatf("st%0d", i), 1, 32'h0);
      expect_rsp($sformatf("st%0d", i), 32'h0, 1'b0);
    end

    // IO output bank writes and read-back.
    send(1'b1, 16'h4000, W, 32'h11223344);
    check("io_sw.reg0", io_out[31:0], 32'h11223344);
    check("io_sw.wren", 32'(dmem_wren), 32'd0);
    expect_rsp("io_sw", 32'h0, 1'b0);
    send(1'b1, 16'h4002, H, 32'h0000BEEF);
    check("io_sh.reg0", io_out[31:0], 32'hBEEF3344);
    expect_rsp("io_sh", 32'h0, 1'b0);
    send(1'b1, 16'h4004, W, 32'hCAFEF00D);
    check("io_sw1.reg1", io_out[63:32], 32'hCAFEF00D);
    check("io_sw1.reg0", io_out[31:0], 32'hBEEF3344);
    expect_rsp("io_sw1", 32'h0, 1'b0);
    send(1'b0, 16'h4000, W, 32'h0);
    check("io_lw.rden", 32'(dmem_rden), 32'd0);
    expect_rsp("io_lw", 32'hBEEF3344, 1'b0);
    send(1'b0, 16'h4003, BU, 32'h0);
    expect_rsp("io_lbu", 32'h000000BE, 1'b0);
    send(1'b0, 16'h4006, H, 32'h0);
    expect_rsp("io_lh", 32'hFFFFCAFE, 1'b0);

    foreach (errs[i]) begin
      send(errs[i].we, errs[i].addr, errs[i].size, 32'hFFFFFFFF);
      check($sformatf("err%0d.rden", i), 32'(dmem_rden), 32'd0);
      check($sformatf("err%0d.wren", i), 32'(dmem_wren), 32'd0);
      expect_rsp($sformatf("err%0d", i), 32'h0, 1'b1);
    end
    check("err.io_reg0", io_out[31:0], 32'hBEEF3344);

    // Request presented while busy must be ignored.
    send(1'b0, 16'h0010, W, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h4000; req_size = W; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    dmem_reply("busy", 0, 32'h0BADF00D);
    expect_rsp("busy", 32'h0BADF00D, 1'b0);
    check("busy.io_reg0", io_out[31:0], 32'hBEEF3344);
    @(posedge clk);
    #1;
    check("busy.no_second", 32'(rsp_valid), 32'd0);

    // Timeout with no ack, then ack arriving in the last timer cycle.
    send(1'b0, 16'h0008, W, 32'h0);
    begin
      logic early;
      early = 1'b0;
      repeat (63) begin
        @(posedge clk);
        #1;
        if (rsp_valid) early = 1'b1;
      end
      check("to.early", 32'(early), 32'd0);
    end
    @(posedge clk);
    #1;
    check("to.rden_off", 32'(dmem_rden), 32'd0);
    expect_rsp("to", 32'h0, 1'b1);
    send(1'b0, 16'h0008, W, 32'h0);
    dmem_reply("to_ack", 63, 32'h12345678);
    expect_rsp("to_ack", 32'h12345678, 1'b0);

    // Asynchronous reset in the middle of a DMEM wait.
    send(1'b0, 16'h000C, W, 32'h0);
    check("arst.rden_pre", 32'(dmem_rden), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst.rden", 32'(dmem_rden), 32'd0);
    check("arst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst.io_reg0", io_out[31:0], 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Input window through the synchroniser.
    @(negedge clk);
    io_in = {32'hDEADBEEF, 32'h00000005};
    send(1'b0, 16'h4800, W, 32'h0);
    expect_rsp("sync.early", 32'h0, 1'b0);
    send(1'b0, 16'h4800, W, 32'h0);
    expect_rsp("sync.in0", 32'h00000005, 1'b0);
    send(1'b0, 16'h4804, W, 32'h0);
    expect_rsp("sync.in1", 32'hDEADBEEF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
